// File: rtl/gcd_lcm_stage.sv
// lcm stage chained behind the gcd block: lcm = (a / g) * b using an iterative
// restoring divider followed by an iterative shift-add multiplier.
module gcd_lcm_stage #(
    parameter int width_p     = 32,
    parameter int ctr_width_p = $clog2(width_p) + 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [2*width_p-1:0]   data_in,
    input  logic [width_p-1:0]     gcd_i,
    input  logic                   v_i,
    output logic                   ready_o,
    output logic [2*width_p-1:0]   data_out,
    output logic                   err_o,
    output logic                   v_o,
    input  logic                   yumi_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e                 state_q;
    logic [ctr_width_p-1:0] cnt_q;
    logic [width_p:0]       rem_q;
    logic [width_p-1:0]     quot_q;
    logic [width_p-1:0]     g_q;
    logic [2*width_p-1:0]   bsh_q;
    logic [2*width_p-1:0]   acc_q;
    logic [2*width_p-1:0]   data_q;
    logic                   err_q;
    logic                   v_q;
    logic                   ready_q;

    logic [width_p-1:0]     a_s;
    logic [width_p-1:0]     b_s;
    logic [width_p:0]       rem_sh_s;
    logic [width_p:0]       rem_d;
    logic [width_p-1:0]     quot_d;
    logic [width_p-1:0]     mquot_d;
    logic [2*width_p-1:0]   acc_d;
    logic [2*width_p-1:0]   bsh_d;

    // One restoring-division step and one shift-add multiply step per cycle.
    always_comb begin
        a_s      = data_in[2*width_p-1:width_p];
        b_s      = data_in[width_p-1:0];
        rem_sh_s = {rem_q[width_p-1:0], quot_q[width_p-1]};
        if (rem_sh_s >= {1'b0, g_q}) begin
            rem_d  = rem_sh_s - {1'b0, g_q};
            quot_d = {quot_q[width_p-2:0], 1'b1};
        end else begin
            rem_d  = rem_sh_s;
            quot_d = {quot_q[width_p-2:0], 1'b0};
        end
        if (quot_q[0]) begin
            acc_d = acc_q + bsh_q;
        end else begin
            acc_d = acc_q;
        end
        mquot_d = {1'b0, quot_q[width_p-1:1]};
        bsh_d   = {bsh_q[2*width_p-2:0], 1'b0};
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            g_q     <= '0;
            bsh_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            v_q     <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (v_i && ready_q) begin
                        quot_q  <= a_s;
                        bsh_q   <= {{width_p{1'b0}}, b_s};
                        g_q     <= gcd_i;
                        rem_q   <= '0;
                        acc_q   <= '0;
                        ready_q <= 1'b0;
                        if ((a_s == '0) || (b_s == '0)) begin
                            state_q <= ST_DONE;
                            data_q  <= '0;
                            err_q   <= 1'b0;
                            v_q     <= 1'b1;
                        end else if (gcd_i == '0) begin
                            state_q <= ST_DONE;
                            data_q  <= '0;
                            err_q   <= 1'b1;
                            v_q     <= 1'b1;
                        end else begin
                            state_q <= ST_DIV;
                            cnt_q   <= ctr_width_p'(width_p);
                        end
                    end
                end
                ST_DIV: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    if (cnt_q == ctr_width_p'(1)) begin
                        state_q <= ST_MUL;
                        cnt_q   <= ctr_width_p'(width_p);
                        acc_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - ctr_width_p'(1);
                    end
                end
                ST_MUL: begin
                    acc_q  <= acc_d;
                    quot_q <= mquot_d;
                    bsh_q  <= bsh_d;
                    cnt_q  <= cnt_q - ctr_width_p'(1);
                    // Last multiplier bit: publish the result on the way into DONE.
                    if (cnt_q == ctr_width_p'(1)) begin
                        state_q <= ST_DONE;
                        data_q  <= acc_d;
                        err_q   <= (rem_q != '0);
                        v_q     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (yumi_i) begin
                        state_q <= ST_IDLE;
                        v_q     <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    v_q     <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign v_o      = v_q;
    assign data_out = data_q;
    assign err_o    = err_q;

    gcd_lcm_stage_chk u_chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_o       (v_q),
        .yumi_i    (yumi_i)
    );

endmodule

// Protocol checker: the consumer may only take a result while one is offered.
module gcd_lcm_stage_chk (
    input logic clk_i,
    input logic reset_n_i,
    input logic v_o,
    input logic yumi_i
);

    a_yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
    );

endmodule

// File: tb/tb_gcd_lcm_stage.sv
// Directed bench for gcd_lcm_stage: hand-computed lcm results, latency,
// back-pressure hold and asynchronous reset mid-division.
module tb_gcd_lcm_stage;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [63:0] data_in;
    logic [31:0] gcd_i;
    logic        v_i;
    logic        ready_o;
    logic [63:0] data_out;
    logic        err_o;
    logic        v_o;
    logic        yumi_i;

    int n_tests = 0;
    int n_fail  = 0;

    gcd_lcm_stage dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_in   (data_in),
        .gcd_i     (gcd_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .data_out  (data_out),
        .err_o     (err_o),
        .v_o       (v_o),
        .yumi_i    (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready_o && n < 300) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!ready_o) check({tag, "_ready_timeout"}, 64'(ready_o), 64'd1);
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] g);
        data_in = {a, b};
        gcd_i   = g;
        v_i     = 1'b1;
        @(posedge clk_i); #1;
        v_i     = 1'b0;
    endtask

    // Latency counts the accept edge as 1.
    task automatic wait_vo(output int lat, output bit rdy_hi);
        lat    = 1;
        rdy_hi = 1'b0;
        while (!v_o && lat < 300) begin
            if (ready_o) rdy_hi = 1'b1;
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic pop(input string tag);
        yumi_i = 1'b1;
        @(posedge clk_i); #1;
        yumi_i = 1'b0;
        check({tag, "_vo_after_yumi"}, 64'(v_o), 64'd0);
        check({tag, "_ready_after_yumi"}, 64'(ready_o), 64'd1);
    endtask

    task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] g, input logic [63:0] exp_d,
                           input logic exp_e, input int exp_lat);
        int lat;
        bit rh;
        wait_ready(tag);
        start(a, b, g);
        wait_vo(lat, rh);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_ready_low"}, 64'(rh), 64'd0);
        check({tag, "_data"}, data_out, exp_d);
        check({tag, "_err"}, 64'(err_o), 64'(exp_e));
        pop(tag);
    endtask

    initial begin
        int  lat;
        bit  rh;
        bit  stable;
        bit  rdy;
        reset_n_i = 1'b0;
        data_in   = 64'd0;
        gcd_i     = 32'd0;
        v_i       = 1'b0;
        yumi_i    = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_vo", 64'(v_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_data", data_out, 64'd0);

        run_txn("t12_18", 32'd12, 32'd18, 32'd6, 64'd36, 1'b0, 65);
        run_txn("tmax", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 64'hFFFF_FFFD_0000_0002, 1'b0, 65);
        run_txn("tbadg", 32'd10, 32'd4, 32'd3, 64'd12, 1'b1, 65);
        run_txn("tzero", 32'd0, 32'd7, 32'd7, 64'd0, 1'b0, 1);
        run_txn("tg0", 32'd5, 32'd5, 32'd0, 64'd0, 1'b1, 1);

        // Back-to-back with the second beat pending while the first result is held.
        wait_ready("b2b");
        start(32'd21, 32'd6, 32'd3);
        wait_vo(lat, rh);
        check("b2b1_latency", 64'(lat), 64'd65);
        data_in = {32'd8, 32'd12};
        gcd_i   = 32'd4;
        v_i     = 1'b1;
        stable  = 1'b1;
        rdy     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            if (data_out !== 64'd42 || v_o !== 1'b1) stable = 1'b0;
            if (ready_o) rdy = 1'b1;
        end
        check("b2b1_data", data_out, 64'd42);
        check("b2b1_stable", 64'(stable), 64'd1);
        check("b2b1_ready_held_low", 64'(rdy), 64'd0);
        yumi_i = 1'b1;
        @(posedge clk_i); #1;
        yumi_i = 1'b0;
        check("b2b_vo_after_yumi", 64'(v_o), 64'd0);
        check("b2b_ready_after_yumi", 64'(ready_o), 64'd1);
        @(posedge clk_i); #1;
        v_i = 1'b0;
        check("b2b2_accepted", 64'(ready_o), 64'd0);
        wait_vo(lat, rh);
        check("b2b2_latency", 64'(lat), 64'd65);
        check("b2b2_data", data_out, 64'd24);
        check("b2b2_err", 64'(err_o), 64'd0);
        pop("b2b2");

        // Asynchronous reset in the middle of division.
        wait_ready("arst");
        start(32'd12, 32'd18, 32'd6);
        repeat (9) @(posedge clk_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("arst_vo", 64'(v_o), 64'd0);
        check("arst_ready", 64'(ready_o), 64'd1);
        check("arst_data", data_out, 64'd0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk_i); #1;
            if (v_o) rdy = 1'b1;
        end
        check("arst_no_stale", 64'(rdy), 64'd0);
        run_txn("t9_6", 32'd9, 32'd6, 32'd3, 64'd18, 1'b0, 65);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
